// File: rtl/tick_level_generator.sv
// tick_level_generator
//   Turns single-cycle ticks into level pulses of programmable width, each
//   followed by a guaranteed minimum low gap.
//
// Parameters
//   WIDTH_BITS  width of the `width` input and of the high-time counter
//   GAP_CYCLES  minimum low cycles after a pulse (0 = no gap)
//   RETRIGGER   1: a tick during HIGH reloads the counter, 0: it is dropped
//
// Ports
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset
//   tick    trigger, every high cycle is one tick
//   width   high time in cycles, sampled on acceptance (0 behaves as 1)
//   level   registered pulse output
//   toggle  registered, inverts on every accepted tick
//   busy    registered, high while in HIGH or GAP
//   done    registered one-cycle pulse in the first low cycle after a pulse
//   drop    registered one-cycle pulse in the cycle after an ignored tick
module tick_level_generator #(
  parameter int WIDTH_BITS = 8,
  parameter int GAP_CYCLES = 2,
  parameter bit RETRIGGER  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [WIDTH_BITS-1:0] width,
  output logic                  level,
  output logic                  toggle,
  output logic                  busy,
  output logic                  done,
  output logic                  drop
);

  localparam int GCNT_BITS = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // With no gap the GAP state is unreachable; load 0 so the constant stays legal.
  localparam logic [GCNT_BITS-1:0] GAP_LOAD =
    GCNT_BITS'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH_BITS-1:0] cnt_q, cnt_d;
  logic [GCNT_BITS-1:0]  gcnt_q, gcnt_d;
  logic                  level_q, level_d;
  logic                  toggle_q, toggle_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  drop_q, drop_d;

  logic                  accept_s;
  logic                  expire_s;
  logic                  ignore_s;
  logic [WIDTH_BITS-1:0] reload_s;

  // Counter reload value: effective width minus one, a zero width acting as one.
  assign reload_s = (width == '0) ? '0 : (width - WIDTH_BITS'(1));

  // State register, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      gcnt_q   <= '0;
      level_q  <= 1'b0;
      toggle_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gcnt_q   <= gcnt_d;
      level_q  <= level_d;
      toggle_q <= toggle_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
    end
  end

  // Next-state and counter logic, plus the accept/expire/ignore events.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gcnt_d   = gcnt_q;
    accept_s = 1'b0;
    expire_s = 1'b0;
    ignore_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d  = ST_HIGH;
          cnt_d    = reload_s;
          accept_s = 1'b1;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_HIGH: begin
        // A retrigger wins over expiry, even on the last high cycle.
        if (tick && (RETRIGGER == 1'b1)) begin
          cnt_d    = reload_s;
          accept_s = 1'b1;
        end else if (cnt_q == '0) begin
          expire_s = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            gcnt_d  = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - WIDTH_BITS'(1);
        end
        if (tick && (RETRIGGER == 1'b0)) begin
          ignore_s = 1'b1;
        end else begin
          ignore_s = 1'b0;
        end
      end
      ST_GAP: begin
        if (gcnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q - GCNT_BITS'(1);
        end
        ignore_s = tick;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        gcnt_d  = '0;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    level_d  = (state_d == ST_HIGH);
    busy_d   = (state_d != ST_IDLE);
    toggle_d = toggle_q ^ accept_s;
    done_d   = expire_s;
    drop_d   = ignore_s;
  end

  assign level  = level_q;
  assign toggle = toggle_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign drop   = drop_q;

endmodule
